// File: rtl/seq_mul64_pkg.sv
// seq_mul64_pkg: shared state encoding and iteration constants for seq_mul64
package seq_mul64_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int MUL_ITERS = 64;
    localparam int CNT_W = 6;
endpackage

// File: rtl/seq_mul64_rdcla.sv
// rdcla: 64-bit carry-lookahead adder built on a parallel-prefix carry tree
module rdcla (
    input  logic [63:0] in1,
    input  logic [63:0] in2,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    logic [63:0] p;
    logic [63:0] gg;
    logic [63:0] pp;
    assign p = in1 ^ in2;
    always_comb begin
        gg = (in1 & in2) | {63'b0, p[0] & cin};
        pp = p;
        for (int k = 0; k < 6; k++) begin
            gg = gg | (pp & (gg << (1 << k)));
            pp = pp & ~(~pp << (1 << k));
        end
    end
    assign sum  = p ^ {gg[62:0], cin};
    assign cout = gg[63];
endmodule

// File: rtl/seq_mul64.sv
// seq_mul64: 64x64 unsigned shift-and-add multiplier, one adder pass per cycle
module seq_mul64
    import seq_mul64_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod
);
    state_t          state;
    state_t          next;
    logic [127:0]    p;
    logic [63:0]     mcand;
    logic [CNT_W-1:0] cnt;
    logic [63:0]     sum;
    logic            cout;
    logic            last;
    rdcla u_rdcla (
        .in1  (p[127:64]),
        .in2  (mcand),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );
    assign last = cnt == CNT_W'(MUL_ITERS - 1);
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = in_valid ? BUSY : IDLE;
            BUSY:    next = last ? DONE : BUSY;
            DONE:    next = out_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign out_prod  = p;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            p     <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else begin
            state <= next;
            if (state == IDLE && in_valid) begin
                mcand <= in_a;
                p     <= {64'b0, in_b};
                cnt   <= '0;
            end else if (state == BUSY) begin
                p   <= p[0] ? {cout, sum, p[63:1]} : {1'b0, p[127:1]};
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_mul64.sv
// tb_seq_mul64: directed table, corner sequences and random streaming vs a plain a*b model
module tb_seq_mul64;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [63:0]  in_a = '0;
    logic [63:0]  in_b = '0;
    logic         out_valid;
    logic         out_ready = 0;
    logic [127:0] out_prod;
    int errors = 0;
    int checks = 0;
    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs[6];
    logic [127:0] q[$];
    seq_mul64 #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] wa = {64'b0, a};
        logic [127:0] wb = {64'b0, b};
        return wa * wb;
    endfunction
    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp);
        int n;
        check({name, " ready"}, in_ready, 1);
        in_a = a;
        in_b = b;
        in_valid = 1;
        tick();
        in_valid = 0;
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check({name, " latency"}, n, 65);
        check({name, " prod"}, out_prod, exp);
    endtask
    task automatic drain(input string name);
        out_ready = 1;
        tick();
        out_ready = 0;
        check({name, " idle ready"}, in_ready, 1);
        check({name, " idle valid"}, out_valid, 0);
    endtask
    initial begin
        vecs[0] = '{64'd3, 64'd5, 128'd15};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vecs[2] = '{64'd0, 64'hDEAD_BEEF, 128'd0};
        vecs[3] = '{64'h1_0000_0000, 64'h1_0000_0000, 128'h1_0000_0000_0000_0000};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000};
        vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'd1, 128'h1234_5678_9ABC_DEF0};
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_prod", out_prod, 0);
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
            drain($sformatf("vec%0d", i));
        end
        run_op("bp", 64'd7, 64'd11, 128'd77);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_a = 64'hAAAA;
            in_b = 64'h5555;
            tick();
            check("bp out_valid", out_valid, 1);
            check("bp in_ready", in_ready, 0);
            check("bp out_prod", out_prod, 128'd77);
        end
        in_valid = 0;
        drain("bp");
        in_a = 64'd123;
        in_b = 64'd456;
        in_valid = 1;
        tick();
        in_valid = 0;
        for (int i = 0; i < 29; i++) tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        check("abort out_valid", out_valid, 0);
        check("abort out_prod", out_prod, 0);
        check("abort in_ready", in_ready, 1);
        run_op("after abort", 64'd7, 64'd9, 128'd63);
        drain("after abort");
        begin
            int sent = 0;
            int got = 0;
            int cyc = 0;
            in_a = {$urandom, $urandom};
            in_b = {$urandom, $urandom};
            in_valid = 1;
            while (got < 1000 && cyc < 80000) begin
                out_ready = $urandom_range(0, 3) != 0;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("stream spurious", out_prod, 'x);
                    end else begin
                        check("stream prod", out_prod, q.pop_front());
                    end
                    got++;
                end
                if (in_valid && in_ready) begin
                    q.push_back(model(in_a, in_b));
                    sent++;
                end
                tick();
                cyc++;
                if (in_valid && !in_ready) begin
                    in_a = $urandom_range(0, 7) == 0 ? '1 : {$urandom, $urandom};
                    in_b = $urandom_range(0, 7) == 0 ? 64'(0) : {$urandom, $urandom};
                end
                in_valid = sent < 1000;
            end
            in_valid = 0;
            out_ready = 0;
            check("stream received", got, 1000);
            check("stream sent", sent, 1000);
            check("stream leftover", q.size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
